// File: rtl/redmule_ldst_arbiter.sv
// Arbiter for the single TCDM port shared by the RedMulE streamer.
// Three load sources (X, W, Y) and one store sink (Z) compete for the port.
// A granted read pushes its source index into an ID FIFO so that the in-order
// read responses can be routed back to the source that issued them.
// Stores have priority, bounded by a starvation counter that forces a waiting
// load through after LD_STARVE consecutive store grants.
module redmule_ldst_arbiter #(
    parameter int unsigned N_LD      = 3,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned LD_STARVE = 8,
    localparam int unsigned LDW      = (N_LD > 1) ? $clog2(N_LD) : 1,
    localparam int unsigned SELW     = LDW + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            enable_i,
    input  logic [N_LD-1:0] ld_req_i,
    output logic [N_LD-1:0] ld_gnt_o,
    output logic [N_LD-1:0] ld_rvalid_o,
    input  logic            st_req_i,
    output logic            st_gnt_o,
    output logic            tcdm_req_o,
    output logic            tcdm_wen_o,
    input  logic            tcdm_gnt_i,
    input  logic            tcdm_r_valid_i,
    output logic [SELW-1:0] sel_o,
    output logic            busy_o,
    output logic [15:0]     ld_cnt_o,
    output logic [15:0]     st_cnt_o,
    output logic            err_o
);

    localparam int unsigned PTRW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CNTW = $clog2(MAX_OUTST + 1);
    localparam int unsigned STW  = $clog2(LD_STARVE + 1);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e            state_q, state_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [LDW-1:0]    rr_q, rr_d;
    logic [STW-1:0]    starve_q, starve_d;
    logic [LDW-1:0]    mem_q [MAX_OUTST];
    logic [PTRW-1:0]   wptr_q, rptr_q;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [15:0]       ld_cnt_q, st_cnt_q;
    logic              err_q;

    logic              fifo_full, fifo_empty;
    logic [N_LD-1:0]   ld_elig;
    logic              cand_valid;
    logic [SELW-1:0]   cand_sel;
    logic [LDW-1:0]    rr_idx;
    logic              req, is_store, gnt;
    logic [SELW-1:0]   sel;
    logic [LDW-1:0]    gnt_idx;
    logic              push, pop;

    // Full is derived from the registered count, so a same-cycle pop does not unblock loads.
    assign fifo_full  = (cnt_q == CNTW'(MAX_OUTST));
    assign fifo_empty = (cnt_q == '0);

    // Candidate selection: store first unless starvation forces a load, else round-robin.
    always_comb begin
        cand_valid = 1'b0;
        cand_sel   = '0;
        rr_idx     = '0;
        ld_elig    = fifo_full ? '0 : ld_req_i;
        if (enable_i && !clear_i) begin
            if (st_req_i && !(starve_q == STW'(LD_STARVE) && (|ld_elig))) begin
                cand_valid = 1'b1;
                cand_sel   = SELW'(N_LD);
            end else begin
                for (int unsigned k = 0; k < N_LD; k++) begin
                    rr_idx = LDW'((32'(rr_q) + k) % N_LD);
                    if (!cand_valid && ld_elig[rr_idx]) begin
                        cand_valid = 1'b1;
                        cand_sel   = SELW'(rr_idx);
                    end
                end
            end
        end
    end

    // Port drive: the latched selection in HOLD, the live candidate in IDLE.
    always_comb begin
        req = 1'b0;
        sel = '0;
        if (state_q == StHold) begin
            req = 1'b1;
            sel = sel_q;
        end else if (cand_valid) begin
            req = 1'b1;
            sel = cand_sel;
        end
        is_store = (sel == SELW'(N_LD));
        gnt      = req && tcdm_gnt_i;
        gnt_idx  = sel[LDW-1:0];
        ld_gnt_o = '0;
        if (gnt && !is_store) begin
            ld_gnt_o[gnt_idx] = 1'b1;
        end
        st_gnt_o   = gnt && is_store;
        tcdm_req_o = req;
        tcdm_wen_o = req && !is_store;
        sel_o      = sel;
    end

    // Response routing: the FIFO head names the source of the returning read.
    always_comb begin
        push        = gnt && !is_store;
        pop         = tcdm_r_valid_i && !fifo_empty;
        ld_rvalid_o = '0;
        if (pop) begin
            ld_rvalid_o[mem_q[rptr_q]] = 1'b1;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Next-state for the lock FSM, round-robin pointer and starvation counter.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_d     = rr_q;
        starve_d = starve_q;
        unique case (state_q)
            StIdle: begin
                if (cand_valid && !tcdm_gnt_i) begin
                    state_d = StHold;
                    sel_d   = cand_sel;
                end
            end
            StHold: begin
                if (tcdm_gnt_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (gnt && !is_store) begin
            rr_d     = (gnt_idx == LDW'(N_LD - 1)) ? '0 : gnt_idx + LDW'(1);
            starve_d = '0;
        end else if (gnt && is_store) begin
            if (|ld_req_i) begin
                starve_d = (starve_q == STW'(LD_STARVE)) ? starve_q : starve_q + STW'(1);
            end else begin
                starve_d = '0;
            end
        end
    end

    // State registers; clear behaves exactly like reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            rr_q     <= '0;
            starve_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            rr_q     <= '0;
            starve_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_q     <= rr_d;
            starve_q <= starve_d;
            cnt_q    <= cnt_d;
            if (push) begin
                mem_q[wptr_q] <= gnt_idx;
                wptr_q        <= wptr_q + PTRW'(1);
                ld_cnt_q      <= ld_cnt_q + 16'd1;
            end
            if (pop) begin
                rptr_q <= rptr_q + PTRW'(1);
            end
            if (st_gnt_o) begin
                st_cnt_q <= st_cnt_q + 16'd1;
            end
            if (tcdm_r_valid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign busy_o   = (|ld_req_i) || st_req_i || (state_q == StHold) || !fifo_empty;
    assign ld_cnt_o = ld_cnt_q;
    assign st_cnt_o = st_cnt_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_redmule_ldst_arbiter.sv
// Bench for redmule_ldst_arbiter: a per-cycle reference model compared against
// the DUT on every falling edge, plus directed scenarios with literal expectations.
module tb_redmule_ldst_arbiter;

    localparam int N_LD      = 3;
    localparam int MAX_OUTST = 4;
    localparam int LD_STARVE = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        enable_i = 1'b0;
    logic [2:0]  ld_req_i = '0;
    logic [2:0]  ld_gnt_o;
    logic [2:0]  ld_rvalid_o;
    logic        st_req_i = 1'b0;
    logic        st_gnt_o;
    logic        tcdm_req_o;
    logic        tcdm_wen_o;
    logic        tcdm_gnt_i = 1'b0;
    logic        tcdm_r_valid_i = 1'b0;
    logic [2:0]  sel_o;
    logic        busy_o;
    logic [15:0] ld_cnt_o;
    logic [15:0] st_cnt_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;

    redmule_ldst_arbiter #(
        .N_LD      (N_LD),
        .MAX_OUTST (MAX_OUTST),
        .LD_STARVE (LD_STARVE)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .enable_i       (enable_i),
        .ld_req_i       (ld_req_i),
        .ld_gnt_o       (ld_gnt_o),
        .ld_rvalid_o    (ld_rvalid_o),
        .st_req_i       (st_req_i),
        .st_gnt_o       (st_gnt_o),
        .tcdm_req_o     (tcdm_req_o),
        .tcdm_wen_o     (tcdm_wen_o),
        .tcdm_gnt_i     (tcdm_gnt_i),
        .tcdm_r_valid_i (tcdm_r_valid_i),
        .sel_o          (sel_o),
        .busy_o         (busy_o),
        .ld_cnt_o       (ld_cnt_o),
        .st_cnt_o       (st_cnt_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: answers each load grant one cycle later, or on demand.
    logic auto_resp = 1'b0;
    logic manual_rv = 1'b0;
    logic resp_pend = 1'b0;
    always @(negedge clk_i) resp_pend = auto_resp && (|ld_gnt_o);
    always @(posedge clk_i) begin
        #2;
        tcdm_r_valid_i = resp_pend || manual_rv;
    end

    // Reference model: owner lock, rotation pointer, starvation count, ID queue.
    bit          m_locked;
    int          m_lsel, m_rr, m_starve, idx;
    int          m_fifo[$];
    logic [15:0] m_ldc, m_stc;
    bit          m_err;
    bit          e_req, e_gnt, e_stg, e_busy, full;
    int          e_sel;
    logic [2:0]  e_ldg, e_rv, elig;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            m_locked = 0; m_lsel = 0; m_rr = 0; m_starve = 0; m_fifo.delete();
            m_ldc = 0; m_stc = 0; m_err = 0;
            check("rst_tcdm_req", 32'(tcdm_req_o), 0);
            check("rst_sel", 32'(sel_o), 0);
            check("rst_busy", 32'(busy_o), 0);
            check("rst_ld_gnt", 32'(ld_gnt_o), 0);
            check("rst_st_gnt", 32'(st_gnt_o), 0);
            check("rst_counts", {ld_cnt_o, st_cnt_o}, 0);
            check("rst_err", 32'(err_o), 0);
        end else begin
            full  = (m_fifo.size() == MAX_OUTST);
            e_req = 0;
            e_sel = 0;
            if (m_locked) begin
                e_req = 1;
                e_sel = m_lsel;
            end else if (enable_i && !clear_i) begin
                elig = full ? 3'b000 : ld_req_i;
                if (st_req_i && !(m_starve == LD_STARVE && elig != 0)) begin
                    e_req = 1;
                    e_sel = N_LD;
                end else begin
                    for (int k = 0; k < N_LD; k++) begin
                        idx = (m_rr + k) % N_LD;
                        if (!e_req && elig[idx]) begin
                            e_req = 1;
                            e_sel = idx;
                        end
                    end
                end
            end
            e_gnt  = e_req && tcdm_gnt_i;
            e_ldg  = (e_gnt && e_sel < N_LD) ? 3'(1 << e_sel) : 3'b000;
            e_stg  = e_gnt && (e_sel == N_LD);
            e_rv   = (tcdm_r_valid_i && m_fifo.size() > 0) ? 3'(1 << m_fifo[0]) : 3'b000;
            e_busy = (ld_req_i != 0) || st_req_i || m_locked || (m_fifo.size() > 0);

            check("cmp_tcdm_req", 32'(tcdm_req_o), 32'(e_req));
            check("cmp_tcdm_wen", 32'(tcdm_wen_o), 32'(e_req && e_sel != N_LD));
            check("cmp_sel", 32'(sel_o), 32'(e_sel));
            check("cmp_ld_gnt", 32'(ld_gnt_o), 32'(e_ldg));
            check("cmp_st_gnt", 32'(st_gnt_o), 32'(e_stg));
            check("cmp_ld_rvalid", 32'(ld_rvalid_o), 32'(e_rv));
            check("cmp_busy", 32'(busy_o), 32'(e_busy));
            check("cmp_ld_cnt", 32'(ld_cnt_o), 32'(m_ldc));
            check("cmp_st_cnt", 32'(st_cnt_o), 32'(m_stc));
            check("cmp_err", 32'(err_o), 32'(m_err));

            if (clear_i) begin
                m_locked = 0; m_lsel = 0; m_rr = 0; m_starve = 0; m_fifo.delete();
                m_ldc = 0; m_stc = 0; m_err = 0;
            end else begin
                if (tcdm_r_valid_i) begin
                    if (m_fifo.size() > 0) void'(m_fifo.pop_front());
                    else m_err = 1;
                end
                if (e_gnt && e_sel < N_LD) begin
                    m_fifo.push_back(e_sel);
                    m_rr     = (e_sel + 1) % N_LD;
                    m_starve = 0;
                    m_ldc    = m_ldc + 16'd1;
                end else if (e_gnt) begin
                    m_starve = (ld_req_i != 0) ? ((m_starve < LD_STARVE) ? m_starve + 1
                                                                         : LD_STARVE) : 0;
                    m_stc    = m_stc + 16'd1;
                end
                m_locked = e_req && !e_gnt;
                m_lsel   = e_sel;
            end
        end
    end

    // One cycle of stimulus: drive after the rising edge, return at the falling edge.
    task automatic cyc(input logic [2:0] ld, input logic st, input logic gnt, input logic en,
                       input logic rv);
        @(posedge clk_i);
        #1;
        ld_req_i   = ld;
        st_req_i   = st;
        tcdm_gnt_i = gnt;
        enable_i   = en;
        manual_rv  = rv;
        clear_i    = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic do_clear();
        @(posedge clk_i);
        #1;
        ld_req_i   = '0;
        st_req_i   = 1'b0;
        tcdm_gnt_i = 1'b0;
        manual_rv  = 1'b0;
        clear_i    = 1'b1;
        @(negedge clk_i);
    endtask

    int n_st, n_ld;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        @(negedge clk_i);
        check("reset_req", 32'(tcdm_req_o), 0);
        check("reset_cnt", 32'(ld_cnt_o), 0);

        // Rotation: X, W, Y, X, W, Y with responses one cycle behind.
        auto_resp = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc(3'b111, 1'b0, 1'b1, 1'b1, 1'b0);
            check("rot_gnt", 32'(ld_gnt_o), 32'(1 << (c % 3)));
            if (c > 0) check("rot_rvalid", 32'(ld_rvalid_o), 32'(1 << ((c - 1) % 3)));
        end
        cyc(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rot_rvalid_last", 32'(ld_rvalid_o), 32'h4);
        check("rot_ld_cnt", 32'(ld_cnt_o), 6);

        // Starvation bound: 8 stores then one X, twice.
        do_clear();
        n_st = 0;
        n_ld = 0;
        for (int c = 0; c < 18; c++) begin
            cyc(3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
            n_st += int'(st_gnt_o);
            n_ld += int'(ld_gnt_o[0]);
            if (c == 8 || c == 17) check("starve_x_gnt", 32'(ld_gnt_o), 32'h1);
            if (c == 7) check("starve_st_gnt", 32'(st_gnt_o), 1);
        end
        check("starve_st_count", n_st, 16);
        check("starve_ld_count", n_ld, 2);
        cyc(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        check("starve_st_cnt", 32'(st_cnt_o), 16);
        check("starve_ld_cnt", 32'(ld_cnt_o), 2);

        // Lock hold: W locked for three cycles despite Z and enable low.
        do_clear();
        cyc(3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        check("disabled_req", 32'(tcdm_req_o), 0);
        cyc(3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
        check("lock_sel0", 32'(sel_o), 1);
        for (int c = 1; c < 3; c++) begin
            cyc(3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
            check("lock_sel", 32'(sel_o), 1);
            check("lock_req", 32'(tcdm_req_o), 1);
        end
        cyc(3'b010, 1'b1, 1'b1, 1'b0, 1'b0);
        check("lock_w_gnt", 32'(ld_gnt_o), 32'h2);
        cyc(3'b000, 1'b1, 1'b1, 1'b1, 1'b0);
        check("lock_z_gnt", 32'(st_gnt_o), 1);
        check("lock_w_rvalid", 32'(ld_rvalid_o), 32'h2);
        cyc(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);

        // FIFO full: four loads outstanding block further loads but not stores.
        auto_resp = 1'b0;
        do_clear();
        for (int c = 0; c < 4; c++) begin
            cyc(3'b111, 1'b0, 1'b1, 1'b1, 1'b0);
            check("full_fill_gnt", 32'(ld_gnt_o), 32'(1 << (c % 3)));
        end
        cyc(3'b111, 1'b0, 1'b1, 1'b1, 1'b0);
        check("full_blocked", 32'(tcdm_req_o), 0);
        cyc(3'b111, 1'b1, 1'b1, 1'b1, 1'b0);
        check("full_store_gnt", 32'(st_gnt_o), 1);
        check("full_store_wen", 32'(tcdm_wen_o), 0);
        cyc(3'b111, 1'b0, 1'b1, 1'b1, 1'b1);
        check("full_pop_rvalid", 32'(ld_rvalid_o), 32'h1);
        check("full_pop_still_blocked", 32'(tcdm_req_o), 0);
        cyc(3'b111, 1'b0, 1'b1, 1'b1, 1'b0);
        check("full_unblock_gnt", 32'(ld_gnt_o), 32'h2);
        for (int c = 0; c < 4; c++) begin
            cyc(3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
            check("full_drain", 32'(ld_rvalid_o), 32'(1 << ((c + 1) % 3)));
        end
        cyc(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        check("full_idle_busy", 32'(busy_o), 0);

        // Error path: response with nothing outstanding.
        cyc(3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
        check("err_no_pulse", 32'(ld_rvalid_o), 0);
        for (int c = 0; c < 3; c++) begin
            cyc(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
            check("err_sticky", 32'(err_o), 1);
        end
        do_clear();
        cyc(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        check("err_cleared", 32'(err_o), 0);

        // Asynchronous reset while holding a lock.
        cyc(3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        check("hold_req", 32'(tcdm_req_o), 1);
        check("hold_busy", 32'(busy_o), 1);
        @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        check("arst_req", 32'(tcdm_req_o), 0);
        check("arst_busy", 32'(busy_o), 0);
        check("arst_sel", 32'(sel_o), 0);
        @(negedge clk_i);
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_req", 32'(tcdm_req_o), 0);
        auto_resp = 1'b1;
        cyc(3'b010, 1'b0, 1'b1, 1'b1, 1'b0);
        check("post_rst_gnt", 32'(ld_gnt_o), 32'h2);
        cyc(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        check("post_rst_rvalid", 32'(ld_rvalid_o), 32'h2);
        check("post_rst_err", 32'(err_o), 0);
        cyc(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
